// File: rtl/lms_iq_pkg.sv
// Shared types and constants for the LMS IQ sample port.
//   tx_state_t : TX interleaver phase (IDLE, PH_I, PH_Q)
//   CNT_W      : width of every error/underrun counter
//   CNT_SAT    : value at which those counters stop incrementing
//   cnt_next() : next counter value, where clear takes priority over increment
package lms_iq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH_I = 2'd1,
    PH_Q = 2'd2
  } tx_state_t;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic             inc,
                                                input logic             clr);
    if (clr)                   return '0;
    if (inc && (c != CNT_SAT)) return c + CNT_W'(1);
    return c;
  endfunction

endpackage

// File: rtl/lms_iq_rx_lane.sv
// One RX channel: registers the pin word (R1), then pairs an I word with the
// following Q word. Bad sequences (orphan Q, I followed by I) bump err_cnt.
//   clk, rst          : sample clock, async active-high reset
//   iqsel, d          : pin IQSEL (1=I) and pin data
//   clr_cnt           : zero err_cnt
//   rx_i, rx_q        : last pair, DW left-justified in OW
//   rx_stb            : one-cycle pulse when a new pair is written
//   err_cnt           : saturating sequence-error count
// Counting is present only when LMS_IQ_ERRCNT_EN is defined; otherwise
// err_cnt is tied to zero.
module lms_iq_rx_lane
  import lms_iq_pkg::*;
#(
  parameter int DW = 12,
  parameter int OW = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iqsel,
  input  logic [DW-1:0]    d,
  input  logic             clr_cnt,
  output logic [OW-1:0]    rx_i,
  output logic [OW-1:0]    rx_q,
  output logic             rx_stb,
  output logic [CNT_W-1:0] err_cnt
);

  logic          r1_vld;
  logic          r1_sel;
  logic [DW-1:0] r1_d;
  logic          pend;
  logic [DW-1:0] pend_i;

  // r1_vld keeps the reset value of R1 from being taken as a Q word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld <= 1'b0;
      r1_sel <= 1'b0;
      r1_d   <= '0;
    end else begin
      r1_vld <= 1'b1;
      r1_sel <= iqsel;
      r1_d   <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= 1'b0;
      pend_i <= '0;
      rx_i   <= '0;
      rx_q   <= '0;
      rx_stb <= 1'b0;
    end else begin
      rx_stb <= 1'b0;
      if (r1_vld) begin
        if (r1_sel) begin
          pend   <= 1'b1;
          pend_i <= r1_d;
        end else if (pend) begin
          rx_i   <= OW'(pend_i) << (OW - DW);
          rx_q   <= OW'(r1_d) << (OW - DW);
          rx_stb <= 1'b1;
          pend   <= 1'b0;
        end
      end
    end
  end

`ifdef LMS_IQ_ERRCNT_EN
  // I while pending (I-I) or Q while not pending (orphan) is an error.
  logic err_inc;
  assign err_inc = r1_vld & (r1_sel == pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= cnt_next(err_cnt, err_inc, clr_cnt);
  end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign err_cnt    = '0;
`endif

endmodule

// File: rtl/lms_iq_port.sv
// LMS RF transceiver IQ sample port.
// RX: NCH independent lanes pair interleaved I/Q pin words into rx_i/rx_q
//     with a per-channel strobe.
// TX: one interleaver for all channels; a pair is accepted from the core
//     when the next phase is PH_I and driven as I (tx_iqsel=0) then Q
//     (tx_iqsel=1). A missing pair is sent as zeros and counted.
// Ports:
//   clk, rst            : sample clock, async active-high reset
//   en                  : TX interleaver enable
//   rx_iqsel, rx_d      : per-channel RX pins
//   rx_i, rx_q, rx_stb  : per-channel paired RX samples and strobe
//   tx_i, tx_q          : TX pair for all channels
//   tx_valid, tx_ready  : TX handshake (tx_ready is combinational)
//   tx_d, tx_iqsel      : TX pins
//   rx_err_cnt          : per-channel RX sequence error counters
//   tx_urun_cnt         : TX underrun counter
//   clr_cnt             : zero all counters
// Define LMS_IQ_ERRCNT_EN to build the counters; otherwise they read 0.
module lms_iq_port
  import lms_iq_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW  = 12,
  parameter int OW  = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       rx_iqsel,
  input  logic [NCH*DW-1:0]    rx_d,
  output logic [NCH*OW-1:0]    rx_i,
  output logic [NCH*OW-1:0]    rx_q,
  output logic [NCH-1:0]       rx_stb,
  input  logic [NCH*DW-1:0]    tx_i,
  input  logic [NCH*DW-1:0]    tx_q,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [NCH*DW-1:0]    tx_d,
  output logic                 tx_iqsel,
  output logic [NCH*CNT_W-1:0] rx_err_cnt,
  output logic [CNT_W-1:0]     tx_urun_cnt,
  input  logic                 clr_cnt
);

  // ---------------- RX ----------------
  for (genvar g = 0; g < NCH; g++) begin : g_rx
    lms_iq_rx_lane #(
      .DW (DW),
      .OW (OW)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .iqsel   (rx_iqsel[g]),
      .d       (rx_d[g*DW +: DW]),
      .clr_cnt (clr_cnt),
      .rx_i    (rx_i[g*OW +: OW]),
      .rx_q    (rx_q[g*OW +: OW]),
      .rx_stb  (rx_stb[g]),
      .err_cnt (rx_err_cnt[g*CNT_W +: CNT_W])
    );
  end

  // ---------------- TX ----------------
  tx_state_t           state, nxt;
  logic [NCH*DW-1:0]   q_hold;
  logic                xfer;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = en ? PH_I : IDLE;
      PH_I:    nxt = PH_Q;
      PH_Q:    nxt = en ? PH_I : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Gated by rst so the port never offers a slot while held in reset.
  assign tx_ready = ~rst & (nxt == PH_I);
  assign xfer     = tx_valid & tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_d     <= '0;
      tx_iqsel <= 1'b0;
      q_hold   <= '0;
    end else begin
      state <= nxt;
      unique case (nxt)
        PH_I: begin
          tx_iqsel <= 1'b0;
          // No transfer: both halves of this pair go out as zeros.
          tx_d     <= xfer ? tx_i : '0;
          q_hold   <= xfer ? tx_q : '0;
        end
        PH_Q: begin
          tx_iqsel <= 1'b1;
          tx_d     <= q_hold;
        end
        default: begin
          tx_iqsel <= 1'b0;
          tx_d     <= '0;
        end
      endcase
    end
  end

`ifdef LMS_IQ_ERRCNT_EN
  logic urun;
  assign urun = (nxt == PH_I) & ~xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_urun_cnt <= '0;
    else     tx_urun_cnt <= cnt_next(tx_urun_cnt, urun, clr_cnt);
  end
`else
  assign tx_urun_cnt = '0;
`endif

endmodule

// File: tb/tb_lms_iq_port.sv
module tb_lms_iq_port;
  localparam int NCH = 2;
  localparam int DW  = 12;
  localparam int OW  = 14;
`ifdef LMS_IQ_ERRCNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en = 1'b0;
  logic                tx_valid = 1'b0;
  logic                clr_cnt = 1'b0;
  logic [NCH-1:0]      rx_iqsel = '0;
  logic [NCH*DW-1:0]   rx_d = '0;
  logic [NCH*DW-1:0]   tx_i = '0;
  logic [NCH*DW-1:0]   tx_q = '0;
  logic [NCH*OW-1:0]   rx_i, rx_q;
  logic [NCH-1:0]      rx_stb;
  logic                tx_ready, tx_iqsel;
  logic [NCH*DW-1:0]   tx_d;
  logic [NCH*16-1:0]   rx_err_cnt;
  logic [15:0]         tx_urun_cnt;

  always #5 clk = ~clk;

  lms_iq_port #(.NCH(NCH), .DW(DW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .rx_iqsel(rx_iqsel), .rx_d(rx_d),
    .rx_i(rx_i), .rx_q(rx_q), .rx_stb(rx_stb), .tx_i(tx_i), .tx_q(tx_q),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_d(tx_d), .tx_iqsel(tx_iqsel),
    .rx_err_cnt(rx_err_cnt), .tx_urun_cnt(tx_urun_cnt), .clr_cnt(clr_cnt)
  );

  int errs = 0;
  int nchk = 0;

  task automatic chk(input string nm, input int ch, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s ch%0d got=%0h exp=%0h t=%0t", nm, ch, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // RX: each channel's pin words form a stream seen one cycle late; a pair
  // is an I word immediately followed by a Q word.
  // TX: slots are 0=idle, 1=I half, 2=Q half.
  bit m_seen[NCH];
  bit m_wsel[NCH];
  int m_wd[NCH];
  bit m_pend[NCH];
  int m_pi[NCH];
  int m_ri[NCH];
  int m_rq[NCH];
  bit m_stb[NCH];
  int m_err[NCH];
  int m_slot;
  int m_hq[NCH];
  int m_td[NCH];
  bit m_tsel;
  int m_urun;

  function automatic int bump(input int c, input bit inc);
    if (CNT_EN == 0) return 0;
    if (clr_cnt) return 0;
    if (inc && c < 65535) return c + 1;
    return c;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_seen[c] = 0; m_wsel[c] = 0; m_wd[c] = 0; m_pend[c] = 0; m_pi[c] = 0;
      m_ri[c] = 0; m_rq[c] = 0; m_stb[c] = 0; m_err[c] = 0; m_hq[c] = 0; m_td[c] = 0;
    end
    m_slot = 0; m_tsel = 0; m_urun = 0;
  endtask

  task automatic model_clk();
    int  nslot;
    bit  inc;
    if (rst) begin model_reset(); return; end
    for (int c = 0; c < NCH; c++) begin
      m_stb[c] = 0;
      inc = 0;
      if (m_seen[c]) begin
        if (m_wsel[c]) begin
          inc = m_pend[c];
          m_pend[c] = 1;
          m_pi[c] = m_wd[c];
        end else if (m_pend[c]) begin
          m_ri[c] = m_pi[c] * (1 << (OW - DW));
          m_rq[c] = m_wd[c] * (1 << (OW - DW));
          m_stb[c] = 1;
          m_pend[c] = 0;
        end else inc = 1;
      end
      m_err[c] = bump(m_err[c], inc);
      m_seen[c] = 1;
      m_wsel[c] = rx_iqsel[c];
      m_wd[c] = int'(rx_d[c*DW +: DW]);
    end
    nslot = (m_slot == 1) ? 2 : (en ? 1 : 0);
    inc = (nslot == 1) && !tx_valid;
    for (int c = 0; c < NCH; c++) begin
      if (nslot == 1) begin
        m_td[c] = tx_valid ? int'(tx_i[c*DW +: DW]) : 0;
        m_hq[c] = tx_valid ? int'(tx_q[c*DW +: DW]) : 0;
      end else if (nslot == 2) m_td[c] = m_hq[c];
      else m_td[c] = 0;
    end
    m_tsel = (nslot == 2);
    m_urun = bump(m_urun, inc);
    m_slot = nslot;
  endtask

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      chk("rx_stb", c, 32'(rx_stb[c]), 32'(m_stb[c]));
      chk("rx_i", c, 32'(rx_i[c*OW +: OW]), m_ri[c]);
      chk("rx_q", c, 32'(rx_q[c*OW +: OW]), m_rq[c]);
      chk("rx_err_cnt", c, 32'(rx_err_cnt[c*16 +: 16]), m_err[c]);
      chk("tx_d", c, 32'(tx_d[c*DW +: DW]), m_td[c]);
    end
    chk("tx_iqsel", 0, 32'(tx_iqsel), 32'(m_tsel));
    chk("tx_ready", 0, 32'(tx_ready), 32'(!rst && en && m_slot != 1));
    chk("tx_urun_cnt", 0, 32'(tx_urun_cnt), m_urun);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic set_rx(input int c, input bit sel, input int d);
    rx_iqsel[c] = sel;
    rx_d[c*DW +: DW] = DW'(d);
  endtask

  task automatic set_tx_all(input int vi, input int vq);
    for (int c = 0; c < NCH; c++) begin
      tx_i[c*DW +: DW] = DW'(vi);
      tx_q[c*DW +: DW] = DW'(vq);
    end
  endtask

  // Called at post-edge +1: asserts reset mid-cycle and checks it is immediate.
  task automatic async_reset_checked();
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_tx_d", 0, 32'(tx_d), 0);
    chk("rst_tx_iqsel", 0, 32'(tx_iqsel), 0);
    chk("rst_tx_ready", 0, 32'(tx_ready), 0);
    chk("rst_rx_i", 0, 32'(rx_i), 0);
    chk("rst_rx_q", 0, 32'(rx_q), 0);
    chk("rst_rx_stb", 0, 32'(rx_stb), 0);
    chk("rst_rx_err", 0, 32'(rx_err_cnt), 0);
    chk("rst_urun", 0, 32'(tx_urun_cnt), 0);
    cyc();
  endtask

  int t1_sel[6] = '{1, 1, 0, 0, 1, 0};
  int t1_dat[6] = '{32'h111, 32'h222, 32'h333, 32'h444, 32'h555, 32'h666};

  initial begin
    model_reset();
    #1 rst = 1'b1;
    cyc(); cyc();
    chk("init_tx_d", 0, 32'(tx_d), 0);
    chk("init_rx_stb", 0, 32'(rx_stb), 0);

    // Directed: nominal RX on ch0, glitch sequence on ch1, continuous TX
    // with one underrun slot and an enable drop after PH_I.
    en = 1'b1; tx_valid = 1'b1;
    set_tx_all(32'h7FF, 32'h800);
    for (int k = 0; k <= 10; k++) begin
      set_rx(0, (k % 2) == 0, ((k % 2) == 0) ? 32'h123 : 32'h456);
      if (k < 6) set_rx(1, t1_sel[k] != 0, t1_dat[k]);
      else       set_rx(1, (k % 2) == 0, 32'h100 + k);
      tx_valid = (k != 6);
      en       = (k < 9);
      if (k == 0) rst = 1'b0;
      cyc();
      if (k == 0) begin
        chk("tx_first_i", 0, 32'(tx_d[DW-1:0]), 32'h7FF);
        chk("tx_first_sel", 0, 32'(tx_iqsel), 0);
      end
      if (k == 1) begin
        chk("tx_first_q", 1, 32'(tx_d[2*DW-1:DW]), 32'h800);
        chk("tx_q_sel", 0, 32'(tx_iqsel), 1);
        chk("rx_stb_early", 0, 32'(rx_stb[0]), 0);
      end
      if (k == 2) begin
        chk("rx_nom_stb", 0, 32'(rx_stb[0]), 1);
        chk("rx_nom_i", 0, 32'(rx_i[OW-1:0]), 32'h048C);
        chk("rx_nom_q", 0, 32'(rx_q[OW-1:0]), 32'h1158);
        chk("rx_ii_err", 1, 32'(rx_err_cnt[31:16]), 32'(CNT_EN));
      end
      if (k == 3) begin
        chk("rx_ii_stb", 1, 32'(rx_stb[1]), 1);
        chk("rx_ii_i", 1, 32'(rx_i[2*OW-1:OW]), 32'h888);
        chk("rx_ii_q", 1, 32'(rx_q[2*OW-1:OW]), 32'hCCC);
      end
      if (k == 4) begin
        chk("rx_orphan_stb", 1, 32'(rx_stb[1]), 0);
        chk("rx_orphan_err", 1, 32'(rx_err_cnt[31:16]), 32'(2 * CNT_EN));
        chk("rx_nom_err", 0, 32'(rx_err_cnt[15:0]), 0);
      end
      if (k == 6) chk("tx_urun_i", 0, 32'(tx_d), 0);
      if (k == 7) begin
        chk("tx_urun_q", 0, 32'(tx_d), 0);
        chk("tx_urun_cnt", 0, 32'(tx_urun_cnt), 32'(CNT_EN));
      end
      if (k == 9) begin
        chk("tx_endrop_q", 0, 32'(tx_d[DW-1:0]), 32'h800);
        chk("tx_endrop_sel", 0, 32'(tx_iqsel), 1);
      end
      if (k == 10) begin
        chk("tx_idle_d", 0, 32'(tx_d), 0);
        chk("tx_idle_sel", 0, 32'(tx_iqsel), 0);
        chk("tx_idle_ready", 0, 32'(tx_ready), 0);
      end
    end

    // Randomized traffic with occasional clears and mid-cycle resets.
    for (int n = 0; n < 800; n++) begin
      en       = ($urandom_range(0, 9) < 8);
      tx_valid = ($urandom_range(0, 3) != 0);
      clr_cnt  = ($urandom_range(0, 31) == 0);
      for (int c = 0; c < NCH; c++) begin
        tx_i[c*DW +: DW] = DW'($urandom);
        tx_q[c*DW +: DW] = DW'($urandom);
        set_rx(c, ($urandom_range(0, 9) == 0) ? rx_iqsel[c] : !rx_iqsel[c], int'($urandom));
      end
      cyc();
      if ($urandom_range(0, 99) == 0) begin
        async_reset_checked();
        rst = 1'b0;
      end
    end
    clr_cnt = 1'b0;

    // Reset while in PH_I with a pending RX I word on ch0.
    en = 1'b1; tx_valid = 1'b1;
    set_tx_all(32'h5A5, 32'h3C3);
    set_rx(0, 1'b1, 32'h321);
    for (int b = 0; b < 4 && m_slot != 1; b++) cyc();
    chk("reach_ph_i", 0, 32'(m_slot), 1);
    async_reset_checked();
    en = 1'b0;
    set_rx(0, 1'b0, 32'h0AA);
    rst = 1'b0;
    cyc();
    set_rx(0, 1'b1, 32'h0BB);
    cyc();
    chk("post_rst_no_stb", 0, 32'(rx_stb[0]), 0);
    set_rx(0, 1'b0, 32'h0CC);
    cyc();
    chk("post_rst_no_stb2", 0, 32'(rx_stb[0]), 0);
    set_rx(0, 1'b1, 32'h0DD);
    cyc();
    chk("post_rst_stb", 0, 32'(rx_stb[0]), 1);
    chk("post_rst_i", 0, 32'(rx_i[OW-1:0]), 32'h02EC);
    chk("post_rst_q", 0, 32'(rx_q[OW-1:0]), 32'h0330);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
